// File: rtl/vc_dest_arbiter_if.sv
// Handshake/data bundle between the VC/D FIFOs and vc_dest_arbiter.
// master = FIFO side (drives heads/status), slave = arbiter.
interface vc_dest_arbiter_if #(
    parameter int BW    = 6,
    parameter int CNT_W = 8
);
    logic             enable;
    logic [3:0]       weight0;
    logic [3:0]       weight1;
    logic             vc0_empty;
    logic             vc1_empty;
    logic [BW-1:0]    vc0_data;
    logic [BW-1:0]    vc1_data;
    logic             d0_almost_full;
    logic             d1_almost_full;
    logic             vc0_pop;
    logic             vc1_pop;
    logic             d0_push;
    logic             d1_push;
    logic [BW-1:0]    d_data_out;
    logic             cur_vc;
    logic [CNT_W-1:0] fwd_cnt_vc0;
    logic [CNT_W-1:0] fwd_cnt_vc1;

    modport master (
        output enable, weight0, weight1, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d_data_out, cur_vc,
               fwd_cnt_vc0, fwd_cnt_vc1
    );

    modport slave (
        input  enable, weight0, weight1, vc0_empty, vc1_empty, vc0_data, vc1_data,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d_data_out, cur_vc,
               fwd_cnt_vc0, fwd_cnt_vc1
    );
endinterface

// File: rtl/vc_dest_arbiter.sv
// Weighted round-robin VC0/VC1 -> D0/D1 scheduler with one-cycle push latency.
// Optional per-VC forwarded-word counters under `VC_ARB_STATS_EN.
module vc_dest_arbiter #(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    vc_dest_arbiter_if.slave  bus
);
    logic          w_elig0, w_elig1, w_elig_cur, w_elig_oth;
    logic [3:0]    w_w0, w_w1, w_w_cur, w_w_oth;
    logic          w_gnt, w_gvc, w_nxt_cur;
    logic [3:0]    w_nxt_cnt;
    logic [BW-1:0] w_gdata;

    logic          r_cur;
    logic [3:0]    r_cnt;
    logic          r_d0_push, r_d1_push;
    logic [BW-1:0] r_data;

    // A VC is eligible only if the FIFO its head word targets can take it.
    assign w_elig0 = bus.enable & ~bus.vc0_empty &
                     ~(bus.vc0_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
    assign w_elig1 = bus.enable & ~bus.vc1_empty &
                     ~(bus.vc1_data[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);

    assign w_w0 = (bus.weight0 == 4'd0) ? 4'd1 : bus.weight0;
    assign w_w1 = (bus.weight1 == 4'd0) ? 4'd1 : bus.weight1;

    assign w_elig_cur = r_cur ? w_elig1 : w_elig0;
    assign w_elig_oth = r_cur ? w_elig0 : w_elig1;
    assign w_w_cur    = r_cur ? w_w1 : w_w0;
    assign w_w_oth    = r_cur ? w_w0 : w_w1;

    always_comb begin
        w_gnt     = 1'b0;
        w_gvc     = r_cur;
        w_nxt_cur = r_cur;
        w_nxt_cnt = r_cnt;
        if (!reset) begin
            if (w_elig_cur && r_cnt != 4'd0) begin
                w_gnt     = 1'b1;
                w_nxt_cnt = r_cnt - 4'd1;
            end else if (w_elig_oth) begin
                w_gnt     = 1'b1;
                w_gvc     = ~r_cur;
                w_nxt_cur = ~r_cur;
                w_nxt_cnt = w_w_oth - 4'd1;
            end else if (w_elig_cur) begin
                // Burst exhausted but the other VC is idle: reload and keep going.
                w_gnt     = 1'b1;
                w_nxt_cnt = w_w_cur - 4'd1;
            end
        end
    end

    assign w_gdata     = w_gvc ? bus.vc1_data : bus.vc0_data;
    assign bus.vc0_pop = w_gnt & ~w_gvc;
    assign bus.vc1_pop = w_gnt &  w_gvc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur     <= 1'b1;
            r_cnt     <= 4'd0;
            r_d0_push <= 1'b0;
            r_d1_push <= 1'b0;
            r_data    <= '0;
        end else begin
            r_cur <= w_nxt_cur;
            r_cnt <= w_nxt_cnt;
            if (w_gnt) begin
                r_data    <= w_gdata;
                r_d0_push <= ~w_gdata[DEST_BIT];
                r_d1_push <=  w_gdata[DEST_BIT];
            end else begin
                r_d0_push <= 1'b0;
                r_d1_push <= 1'b0;
            end
        end
    end

    assign bus.d0_push    = r_d0_push;
    assign bus.d1_push    = r_d1_push;
    assign bus.d_data_out = r_data;
    assign bus.cur_vc     = r_cur;

`ifdef VC_ARB_STATS_EN
    logic [CNT_W-1:0] r_fwd0, r_fwd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fwd0 <= '0;
            r_fwd1 <= '0;
        end else begin
            if (bus.vc0_pop) r_fwd0 <= r_fwd0 + CNT_W'(1);
            if (bus.vc1_pop) r_fwd1 <= r_fwd1 + CNT_W'(1);
        end
    end

    assign bus.fwd_cnt_vc0 = r_fwd0;
    assign bus.fwd_cnt_vc1 = r_fwd1;
`else
    assign bus.fwd_cnt_vc0 = '0;
    assign bus.fwd_cnt_vc1 = '0;
`endif
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench for vc_dest_arbiter: queue-backed VC FIFOs, a rule-level scheduler model,
// a directed vector table, hand-written corner sequences and a random soak.
module tb_vc_dest_arbiter;
    localparam int BW = 6, DB = 4, CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_dest_arbiter_if #(.BW(BW), .CNT_W(CW)) bus();

    vc_dest_arbiter #(.BW(BW), .DEST_BIT(DB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_chk = 0, n_fail = 0;

    logic [BW-1:0] q0[$], q1[$];
    bit en, af0, af1;
    logic [3:0] wt0, wt1;

    // Model: owner of the current burst and words still owed to it.
    int m_cur, m_cnt, m_c0, m_c1;
    bit m_push0, m_push1;
    logic [BW-1:0] m_data;
    bit s_pop0, s_pop1, s_d0p, s_d1p;

    typedef struct { bit en; bit pop0; bit pop1; bit d0p; bit d1p; } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wt(input int v);
        int w;
        w = (v == 0) ? int'(bus.weight0) : int'(bus.weight1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit elig(input int v);
        logic [BW-1:0] h;
        if (!en) return 0;
        if (v == 0) begin if (q0.size() == 0) return 0; h = q0[0]; end
        else        begin if (q1.size() == 0) return 0; h = q1[0]; end
        return h[DB] ? !af1 : !af0;
    endfunction

    task automatic arbitrate(output int g, output int ncur, output int ncnt);
        int oth;
        oth = 1 - m_cur;
        g = -1; ncur = m_cur; ncnt = m_cnt;
        if (reset) return;
        if (elig(m_cur) && m_cnt != 0) begin g = m_cur; ncnt = m_cnt - 1; end
        else if (elig(oth)) begin g = oth; ncur = oth; ncnt = wt(oth) - 1; end
        else if (elig(m_cur)) begin g = m_cur; ncnt = wt(m_cur) - 1; end
    endtask

    task automatic drive_inputs();
        bus.enable = en;
        bus.weight0 = wt0;
        bus.weight1 = wt1;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;
        bus.vc0_empty = (q0.size() == 0);
        bus.vc1_empty = (q1.size() == 0);
        bus.vc0_data = (q0.size() != 0) ? q0[0] : BW'($urandom);
        bus.vc1_data = (q1.size() != 0) ? q1[0] : BW'($urandom);
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic tick();
        int g, ncur, ncnt;
        logic [BW-1:0] w;
        drive_inputs();
        @(negedge clk);
        arbitrate(g, ncur, ncnt);
        s_pop0 = bus.vc0_pop; s_pop1 = bus.vc1_pop;
        s_d0p = bus.d0_push;  s_d1p = bus.d1_push;
        chk("vc0_pop", bus.vc0_pop, g == 0);
        chk("vc1_pop", bus.vc1_pop, g == 1);
        chk("d0_push", bus.d0_push, m_push0);
        chk("d1_push", bus.d1_push, m_push1);
        chk("d_data_out", bus.d_data_out, m_data);
        chk("cur_vc", bus.cur_vc, m_cur);
        chk("fwd_cnt_vc0", bus.fwd_cnt_vc0, m_c0);
        chk("fwd_cnt_vc1", bus.fwd_cnt_vc1, m_c1);
        @(posedge clk);
        if (reset) begin
            m_cur = 1; m_cnt = 0; m_push0 = 0; m_push1 = 0; m_data = '0; m_c0 = 0; m_c1 = 0;
        end else begin
            if (g >= 0) begin
                w = (g == 0) ? q0[0] : q1[0];
                m_data = w; m_push0 = !w[DB]; m_push1 = w[DB];
`ifdef VC_ARB_STATS_EN
                if (g == 0) m_c0 = (m_c0 + 1) % (1 << CW);
                else        m_c1 = (m_c1 + 1) % (1 << CW);
`endif
            end else begin
                m_push0 = 0; m_push1 = 0;
            end
            m_cur = ncur; m_cnt = ncnt;
        end
        #1;
        if (g == 0) void'(q0.pop_front());
        if (g == 1) void'(q1.pop_front());
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic fill(input int n, input logic [BW-1:0] mask, input logic [BW-1:0] setb);
        q0.delete(); q1.delete();
        for (int i = 0; i < n; i++) begin
            q0.push_back((BW'($urandom) & mask) | setb);
            q1.push_back((BW'($urandom) & mask) | setb);
        end
    endtask

    initial begin
        vec_t tbl[9];
        int p1, d1;
        tbl = '{'{1,1,0,0,0}, '{1,1,0,1,0}, '{1,0,1,1,0}, '{1,1,0,1,0}, '{1,1,0,1,0},
                '{1,0,1,1,0}, '{1,1,0,1,0}, '{0,0,0,1,0}, '{0,0,0,0,0}};
        m_cur = 1; m_cnt = 0; m_push0 = 0; m_push1 = 0; m_data = '0; m_c0 = 0; m_c1 = 0;
        en = 1; af0 = 0; af1 = 0; wt0 = 4'd2; wt1 = 4'd1;
        fill(4, '1, '0);
        drive_inputs();
        @(posedge clk); #1;

        // Reset held 3 cycles with both VCs non-empty.
        do_reset(3);
        chk("rst_pop0", s_pop0, 0);
        chk("rst_pop1", s_pop1, 0);
        chk("rst_cur_vc", bus.cur_vc, 1);
        chk("rst_data", bus.d_data_out, 0);
        chk("rst_cnt0", bus.fwd_cnt_vc0, 0);

        // Weights 2/1, all heads to D0, then enable dropped at row 7.
        fill(20, 6'h2F, 6'h00);
        do_reset(1);
        for (int k = 0; k < 9; k++) begin
            en = tbl[k].en;
            tick();
            chk($sformatf("tbl%0d_pop0", k), s_pop0, tbl[k].pop0);
            chk($sformatf("tbl%0d_pop1", k), s_pop1, tbl[k].pop1);
            chk($sformatf("tbl%0d_d0p", k), s_d0p, tbl[k].d0p);
            chk($sformatf("tbl%0d_d1p", k), s_d1p, tbl[k].d1p);
        end
        en = 1;

        // VC0 empty, VC1 holds five D1 words.
        q0.delete(); q1.delete();
        do_reset(1);
        repeat (5) q1.push_back(6'h10);
        p1 = 0; d1 = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            p1 += s_pop1; d1 += s_d1p;
            if (k == 5) chk("vc1_burst_data", bus.d_data_out, 6'h10);
        end
        chk("vc1_pop_count", p1, 5);
        chk("d1_push_count", d1, 5);

        // D1 almost full blocks VC0 (head to D1) but not VC1 (head to D0).
        q0.delete(); q1.delete();
        do_reset(1);
        q0.push_back(6'h10); q1.push_back(6'h01);
        af1 = 1;
        tick();
        chk("af_pop0_blocked", s_pop0, 0);
        chk("af_pop1_go", s_pop1, 1);
        tick();
        chk("af_pop0_still", s_pop0, 0);
        af1 = 0;
        tick();
        chk("af_release_pop0", s_pop0, 1);

        // Zero weights -> strict alternation.
        wt0 = 0; wt1 = 0;
        fill(12, '1, '0);
        do_reset(1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("alt%0d_pop0", k), s_pop0, (k % 2) == 0);
        end
`ifdef VC_ARB_STATS_EN
        chk("alt_cnt0", bus.fwd_cnt_vc0, 5);
        chk("alt_cnt1", bus.fwd_cnt_vc1, 5);
`else
        chk("alt_cnt0", bus.fwd_cnt_vc0, 0);
        chk("alt_cnt1", bus.fwd_cnt_vc1, 0);
`endif

        // Random soak; long reset-free phase lets counters wrap.
        q0.delete(); q1.delete();
        do_reset(1);
        for (int k = 0; k < 1000; k++) begin
            en  = ($urandom_range(9) != 0);
            af0 = ($urandom_range(4) == 0);
            af1 = ($urandom_range(4) == 0);
            if ($urandom_range(7) == 0) wt0 = 4'($urandom);
            if ($urandom_range(7) == 0) wt1 = 4'($urandom);
            reset = (k > 700) && ($urandom_range(49) == 0);
            if (q0.size() < 8 && $urandom_range(3) != 0) q0.push_back(BW'($urandom));
            if (q1.size() < 8 && $urandom_range(3) != 0) q1.push_back(BW'($urandom));
            tick();
        end
        reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
